mips_alu_hilo_div: RTL and testbench



---
 rtl/mips_alu_hilo_div.sv | 172 +++++++++++++++++
 tb/tb_mips_alu_hilo_div.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_hilo_div.sv
// HI/LO companion unit for the MIPS execute stage. It holds the architectural
// HI/LO pair, services MFHI/MFLO/MTHI/MTLO, and runs DIVU/DIVS on an iterative
// restoring divider. The divider writes the quotient to LO and the remainder
// to HI.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. While the unit is busy the requester must hold
// req_valid, req_op and the operands stable. rsp_valid is a one-cycle pulse with
// no backpressure.
module mips_alu_hilo_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              div_zero,
  output logic [1:0]        state_dbg
);

  localparam logic [2:0] OP_MFHI = 3'd0;
  localparam logic [2:0] OP_MFLO = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_DIVU = 3'd4;
  localparam logic [2:0] OP_DIVS = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Divider working registers. For a divide by zero, quo keeps data1 as
  // latched, because FIX copies that value to HI.
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;
  logic              neg_r;
  logic              zero_flag;

  logic              accept;
  logic              div_start;
  logic              d2_zero;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   rem_sub;
  logic              take;
  logic [DATA_W-1:0] quo_sh;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign accept    = req_valid && req_ready;
  assign div_start = accept && ((req_op == OP_DIVU) || (req_op == OP_DIVS));
  assign d2_zero   = (data2 == '0);

  // Operand sign flags and magnitudes. Sign flags are set only for DIVS.
  always_comb begin
    a_neg = (req_op == OP_DIVS) && data1[DATA_W-1];
    b_neg = (req_op == OP_DIVS) && data2[DATA_W-1];
    a_mag = a_neg ? (~data1 + 1'b1) : data1;
    b_mag = b_neg ? (~data2 + 1'b1) : data2;
  end

  // One restoring step. The shifted remainder is one bit wider than the data
  // path, so the borrow out of the subtract is the compare result.
  always_comb begin
    rem_sh  = {rem, quo[DATA_W-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    take    = ~rem_sub[DATA_W];
    quo_sh  = {quo[DATA_W-2:0], take};
    quo_fix = neg_q ? (~quo + 1'b1) : quo;
    rem_fix = neg_r ? (~rem + 1'b1) : rem;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (div_start) state_nxt = d2_zero ? S_FIX : S_DIV;
      S_DIV:   if (cnt == CNT_W'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // HI/LO, read response and divider datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi        <= '0;
      lo        <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      div_zero  <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      div_zero  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MFHI: begin rsp_data <= hi; rsp_valid <= 1'b1; end
              OP_MFLO: begin rsp_data <= lo; rsp_valid <= 1'b1; end
              OP_MTHI: hi <= data1;
              OP_MTLO: lo <= data1;
              OP_DIVU, OP_DIVS: begin
                rem       <= '0;
                quo       <= d2_zero ? data1 : a_mag;
                dvs       <= b_mag;
                cnt       <= CNT_W'(DATA_W);
                neg_q     <= a_neg ^ b_neg;
                neg_r     <= a_neg;
                zero_flag <= d2_zero;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          rem <= take ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          quo <= quo_sh;
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (zero_flag) begin
            hi       <= quo;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_hilo_div.sv
// Directed bench for mips_alu_hilo_div. A transaction-level HI/LO model runs
// beside the DUT and every output is compared on each falling edge. Literal
// expectations for the directed vectors pin the model.
module tb_mips_alu_hilo_div;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'd0;
  logic [W-1:0] data1 = '0;
  logic [W-1:0] data2 = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         div_zero;
  logic [1:0]   state_dbg;

  mips_alu_hilo_div #(.DATA_W(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .data1     (data1),
    .data2     (data2),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file plus a busy countdown with pending results.
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rsp = '0;
  logic         m_rv = 1'b0, m_dz = 1'b0;
  logic [W-1:0] p_hi = '0, p_lo = '0;
  logic         p_z = 1'b0;
  int           m_cnt = 0;
  int           sa, sb;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = '0; m_lo = '0; m_rsp = '0; m_rv = 1'b0; m_dz = 1'b0; m_cnt = 0;
    end else begin
      m_rv = 1'b0;
      m_dz = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_dz = p_z; end
      end else if (req_valid) begin
        case (req_op)
          3'd0: begin m_rsp = m_hi; m_rv = 1'b1; end
          3'd1: begin m_rsp = m_lo; m_rv = 1'b1; end
          3'd2: m_hi = data1;
          3'd3: m_lo = data1;
          3'd4, 3'd5: begin
            if (data2 == '0) begin
              p_hi = data1; p_lo = '1; p_z = 1'b1; m_cnt = 1;
            end else begin
              p_z = 1'b0; m_cnt = W + 1;
              if (req_op == 3'd4) begin
                p_lo = data1 / data2; p_hi = data1 % data2;
              end else if (data1 == 32'h8000_0000 && data2 == 32'hFFFF_FFFF) begin
                p_lo = 32'h8000_0000; p_hi = '0;
              end else begin
                sa = data1; sb = data2;
                p_lo = sa / sb; p_hi = sa % sb;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (reset_n && chk_en) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", busy, (m_cnt > 0));
      check("req_ready", req_ready, (m_cnt == 0));
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_data", rsp_data, m_rsp);
      check("div_zero", div_zero, m_dz);
    end
  end

  // Driver: present a request (called at a falling edge), hold until accepted.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waits);
    req_valid = 1'b1; req_op = op; data1 = a; data2 = b; waits = 0;
    while (!req_ready && waits < 200) begin waits++; @(negedge clock); end
    if (waits >= 200) check("accept_timeout", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clock); end
    if (n >= 200) check("idle_timeout", busy, 0);
  endtask

  logic [2:0]   t_op [6];
  logic [W-1:0] t_a  [6];
  logic [W-1:0] t_b  [6];
  logic [W-1:0] t_lo [6];
  logic [W-1:0] t_hi [6];

  initial begin
    int w, n;
    t_op = '{3'd4, 3'd5, 3'd5, 3'd4, 3'd4, 3'd5};
    t_a  = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF8, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF};
    t_b  = '{32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd5, 32'h0001_0000, 32'd0};
    t_lo = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF};
    t_hi = '{32'd0, 32'd1, 32'hFFFF_FFFE, 32'd0, 32'h0000_5678, 32'hFFFF_FFFF};

    // Power-on reset.
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk_en = 1'b1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_state", state_dbg, 0);

    // Moves and back-to-back reads.
    issue(3'd2, 32'hDEAD_BEEF, 0, w);
    check("mthi_vis", hi, 32'hDEAD_BEEF);
    issue(3'd3, 32'h1234_5678, 0, w);
    check("mtlo_vis", lo, 32'h1234_5678);
    issue(3'd0, 0, 0, w);
    check("mfhi_valid", rsp_valid, 1);
    check("mfhi_data", rsp_data, 32'hDEAD_BEEF);
    issue(3'd1, 0, 0, w);
    check("mflo_valid", rsp_valid, 1);
    check("mflo_data", rsp_data, 32'h1234_5678);
    @(negedge clock);
    check("rsp_pulse_end", rsp_valid, 0);

    // DIVU 100 / 7 with an MFLO held during busy.
    issue(3'd4, 32'd100, 32'd7, w);
    check("divu_busy", busy, 1);
    issue(3'd1, 0, 0, w);
    check("divu_ready_low_cycles", w, 33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("held_mflo_valid", rsp_valid, 1);
    check("held_mflo_data", rsp_data, 32'd14);
    @(negedge clock);
    check("held_mflo_once", rsp_valid, 0);

    // Signed divides.
    issue(3'd5, 32'hFFFF_FFF9, 32'd2, w);
    wait_idle(n);
    check("divs_busy_cycles", n, 33);
    check("divs_lo", lo, 32'hFFFF_FFFD);
    check("divs_hi", hi, 32'hFFFF_FFFF);
    issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, w);
    wait_idle(n);
    check("divs_min_lo", lo, 32'h8000_0000);
    check("divs_min_hi", hi, 32'd0);

    // Extra directed vectors.
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], w);
      wait_idle(n);
      check($sformatf("tbl%0d_lo", i), lo, t_lo[i]);
      check($sformatf("tbl%0d_hi", i), hi, t_hi[i]);
    end

    // No-op opcodes leave everything alone (model compare covers it).
    issue(3'd6, 32'hAAAA_AAAA, 32'd1, w);
    issue(3'd7, 32'h5555_5555, 32'd0, w);
    check("noop_busy", busy, 0);

    // Divide by zero.
    issue(3'd4, 32'd5, 32'd0, w);
    check("dz_busy", busy, 1);
    @(negedge clock);
    check("dz_busy_end", busy, 0);
    check("dz_pulse", div_zero, 1);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    @(negedge clock);
    check("dz_pulse_end", div_zero, 0);

    // Reset in the middle of a divide.
    issue(3'd4, 32'hFFFF_FFFF, 32'd3, w);
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_state", state_dbg, 0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    issue(3'd4, 32'd9, 32'd3, w);
    wait_idle(n);
    check("post_rst_busy_cycles", n, 33);
    check("post_rst_lo", lo, 32'd3);
    check("post_rst_hi", hi, 32'd0);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
